mem_port_scheduler: RTL

//  Shares the single 32x16 program/data memory between the CPU core and a host loader port.

---
 rtl/mvl_mem_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 39 +++
 rtl/mem_port_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mvl_mem_pkg.sv
// Shared types and constants for the memory port scheduler slice.
package mvl_mem_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 16;
    localparam int PROT_LIMIT = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } run_state_t;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; a contended cycle goes to whichever side did not win last.
import mvl_mem_pkg::*;

module rr_arbiter_2 (
    input  logic clock,
    input  logic reset,
    input  logic req_core,
    input  logic req_host,
    output logic gnt_core,
    output logic gnt_host
);

    req_id_t last_winner_r;

    // Grant decision: a lone request always wins, contention alternates.
    always_comb begin
        gnt_core = 1'b0;
        gnt_host = 1'b0;
        if (req_core && req_host) begin
            gnt_core = (last_winner_r == HOST);
            gnt_host = (last_winner_r == CORE);
        end else begin
            gnt_core = req_core;
            gnt_host = req_host;
        end
    end

    // Remember the most recent winner for the next contended cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_winner_r <= HOST;
        end else if (gnt_core) begin
            last_winner_r <= CORE;
        end else if (gnt_host) begin
            last_winner_r <= HOST;
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the program/data memory between core and host and sequences run control.
// Optional host write protection while running is enabled by defining MEM_ARB_WPROT_EN.
import mvl_mem_pkg::*;

module mem_port_scheduler (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              host_run,
    input  logic              core_halted,
    output logic              start_execution,
    output logic              core_rst,
    output logic              wprot_err
);

`ifdef MEM_ARB_WPROT_EN
    localparam logic WPROT_EN = 1'b1;
`else
    localparam logic WPROT_EN = 1'b0;
`endif

    run_state_t state_r;
    logic       core_rvalid_r;
    logic       host_rvalid_r;
    logic       wprot_err_r;
    logic       gnt_core_s;
    logic       gnt_host_s;
    logic       blocked_s;

    rr_arbiter_2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .req_core (core_req && (state_r == RUN)),
        .req_host (host_req),
        .gnt_core (gnt_core_s),
        .gnt_host (gnt_host_s)
    );

    // Grant and memory mux; grants are forced low while reset is asserted.
    always_comb begin
        core_gnt  = gnt_core_s && !reset;
        host_gnt  = gnt_host_s && !reset;
        blocked_s = WPROT_EN && host_gnt && host_we && (state_r == RUN)
                    && ({1'b0, host_addr} < (ADDR_W + 1)'(PROT_LIMIT));
        mem_en    = (core_gnt || host_gnt) && !blocked_s;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt && !blocked_s) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Read data is steered only to the owner of the read issued last cycle.
    always_comb begin
        core_rvalid = core_rvalid_r;
        host_rvalid = host_rvalid_r;
        wprot_err   = wprot_err_r;
        core_rdata  = core_rvalid_r ? mem_rdata : {DATA_W{1'b0}};
        host_rdata  = host_rvalid_r ? mem_rdata : {DATA_W{1'b0}};
    end

    // Read-owner tracking and protection error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_rvalid_r <= 1'b0;
            host_rvalid_r <= 1'b0;
            wprot_err_r   <= 1'b0;
        end else begin
            core_rvalid_r <= core_gnt && !core_we;
            host_rvalid_r <= host_gnt && !host_we;
            wprot_err_r   <= blocked_s;
        end
    end

    // Run-control FSM; core_rst marks the first RUN cycle after a restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= LOAD;
            start_execution <= 1'b0;
            core_rst        <= 1'b0;
        end else begin
            core_rst <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (host_run) begin
                        state_r         <= RUN;
                        start_execution <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_halted) begin
                        state_r         <= HALTED;
                        start_execution <= 1'b0;
                    end
                end
                HALTED: begin
                    if (host_run) begin
                        state_r         <= RUN;
                        start_execution <= 1'b1;
                        core_rst        <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= LOAD;
                    start_execution <= 1'b0;
                end
            endcase
        end
    end

endmodule
